// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle RV64 divider: op codes, FSM states and latched control bits.
package div_unit_pkg;

  localparam int DIV_XLEN = 64;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  localparam logic [1:0] DIV_ST_IDLE  = 2'd0;
  localparam logic [1:0] DIV_ST_CALC  = 2'd1;
  localparam logic [1:0] DIV_ST_FIXUP = 2'd2;
  localparam logic [1:0] DIV_ST_DONE  = 2'd3;

  typedef struct packed {
    logic is_rem;
    logic is_word;
    logic q_neg;
    logic r_neg;
  } div_ctrl_t;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor when it fits.
// Purely combinational; the caller registers the outputs.
module div_unit_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] quo_sh;
  logic            fits;

  // rem stays below dvs, so the shifted partial remainder needs one extra bit
  assign shifted = {rem, quo[XLEN-1]};
  assign quo_sh  = {quo[XLEN-2:0], 1'b0};
  assign fits    = shifted >= {1'b0, dvs};

  assign rem_nxt = fits ? (shifted[XLEN-1:0] - dvs) : shifted[XLEN-1:0];
  assign quo_nxt = fits ? (quo_sh | {{(XLEN-1){1'b0}}, 1'b1}) : quo_sh;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU(+W); result 1 cycle after accept for b==0/overflow, else N+2.
// Result held in DONE until out_ready; kill aborts from any state and beats both handshakes.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_word,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  logic [1:0]      state;
  logic [6:0]      count;
  logic [6:0]      n_last;
  div_ctrl_t       ctrl;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;

  logic            sgn;
  logic [XLEN-1:0] ext_a;
  logic [XLEN-1:0] ext_b;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;
  logic [XLEN-1:0] quo_init;

  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] fix_res;

  assign in_ready = (state == DIV_ST_IDLE) && !kill;
  assign busy     = (state != DIV_ST_IDLE);

  // Operand preparation from the live request; only consumed on the accept edge
  always_comb begin
    sgn      = is_signed_op(op);
    ext_a    = a;
    ext_b    = b;
    if (is_word) begin
      ext_a = sgn ? sext32(a[31:0]) : {{(XLEN-32){1'b0}}, a[31:0]};
      ext_b = sgn ? sext32(b[31:0]) : {{(XLEN-32){1'b0}}, b[31:0]};
    end
    sa       = sgn && ext_a[XLEN-1];
    sb       = sgn && ext_b[XLEN-1];
    mag_a    = sa ? -ext_a : ext_a;
    mag_b    = sb ? -ext_b : ext_b;
    div_zero = (ext_b == '0);
    if (is_word)
      ovf = sgn && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    else
      ovf = sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero || ovf;
    // REM by zero and DIV overflow both return the (word-extended) dividend
    spec_res = is_word ? sext32(a[31:0]) : a;
    if (div_zero && !op[1])
      spec_res = '1;
    else if (ovf && op[1])
      spec_res = '0;
    // Word operands are pre-aligned to the top so 32 iterations leave the quotient in [31:0]
    quo_init = is_word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
  end

  div_unit_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    q_fix   = ctrl.q_neg ? -quo : quo;
    r_fix   = ctrl.r_neg ? -rem : rem;
    sel     = ctrl.is_rem ? r_fix : q_fix;
    fix_res = ctrl.is_word ? sext32(sel[31:0]) : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_ST_IDLE;
      count     <= '0;
      n_last    <= '0;
      ctrl      <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      tag_out   <= '0;
    end else if (kill) begin
      state     <= DIV_ST_IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          if (in_valid) begin
            ctrl.is_rem  <= op[1];
            ctrl.is_word <= is_word;
            ctrl.q_neg   <= sa ^ sb;
            ctrl.r_neg   <= sa;
            rem          <= '0;
            quo          <= quo_init;
            dvs          <= mag_b;
            count        <= '0;
            n_last       <= is_word ? 7'd31 : 7'd63;
            tag_out      <= tag_in;
            if (special) begin
              result    <= spec_res;
              out_valid <= 1'b1;
              state     <= DIV_ST_DONE;
            end else begin
              state     <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 7'd1;
          if (count == n_last)
            state <= DIV_ST_FIXUP;
        end
        DIV_ST_FIXUP: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DIV_ST_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DIV_ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: values, latency, tags, backpressure, kill and reset abort.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        is_word;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  tag_in;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [4:0]  tag_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  div_unit #(.XLEN(64), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .is_word   (is_word),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge; it is taken on the following posedge, then inputs are scrambled.
  task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                       input logic [4:0] t);
    @(negedge clk);
    op = o; is_word = w; a = x; b = y; tag_in = t; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h3; tag_in = 5'd0; op = 2'd1; is_word = 1'b0;
  endtask

  // lat counts negedges after the accept edge until out_valid is seen (1 == visible at edge T+1); 0 on timeout.
  task automatic wait_out(output int lat);
    int  n;
    logic seen;
    n = 0; seen = 1'b0; lat = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
    end
    if (seen) lat = n;
  endtask

  task automatic pop;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = 2'd0; is_word = 1'b0; a = '0; b = '0; tag_in = '0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (tag_out !== 5'd0) begin bad++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_unsigned;
    int lat;
    issue(2'd1, 1'b0, 64'd100, 64'd7, 5'd3);
    wait_out(lat);
    total++; if (lat !== 66) begin bad++; $display("FAIL divu_latency got=%0d exp=66", lat); end
    total++; if (result !== 64'd14) begin bad++; $display("FAIL divu_result got=%h exp=%h", result, 64'd14); end
    total++; if (tag_out !== 5'd3) begin bad++; $display("FAIL divu_tag got=%h exp=3", tag_out); end
    pop();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL divu_drain got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL divu_ready_after got=%b exp=1", in_ready); end
    issue(2'd3, 1'b0, 64'd100, 64'd7, 5'd17);
    wait_out(lat);
    total++; if (lat !== 66) begin bad++; $display("FAIL remu_latency got=%0d exp=66", lat); end
    total++; if (result !== 64'd2) begin bad++; $display("FAIL remu_result got=%h exp=%h", result, 64'd2); end
    total++; if (tag_out !== 5'd17) begin bad++; $display("FAIL remu_tag got=%h exp=11", tag_out); end
    pop();
  endtask

  task automatic test_signed;
    int lat;
    issue(2'd0, 1'b0, -64'sd7, 64'd2, 5'd4);
    wait_out(lat);
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg got=%h exp=fffffffffffffffd", result); end
    pop();
    issue(2'd2, 1'b0, -64'sd7, 64'd2, 5'd5);
    wait_out(lat);
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rem_neg_dividend got=%h exp=ffffffffffffffff", result); end
    pop();
    issue(2'd2, 1'b0, 64'd7, -64'sd2, 5'd6);
    wait_out(lat);
    total++; if (result !== 64'd1) begin bad++; $display("FAIL rem_neg_divisor got=%h exp=1", result); end
    total++; if (lat !== 66) begin bad++; $display("FAIL rem_latency got=%0d exp=66", lat); end
    pop();
  endtask

  task automatic test_special;
    int lat;
    issue(2'd0, 1'b0, 64'd55, 64'd0, 5'd7);
    wait_out(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", lat); end
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL div0_result got=%h exp=all ones", result); end
    pop();
    issue(2'd3, 1'b0, 64'h1234, 64'd0, 5'd8);
    wait_out(lat);
    total++; if (result !== 64'h1234) begin bad++; $display("FAIL remu0_result got=%h exp=1234", result); end
    total++; if (tag_out !== 5'd8) begin bad++; $display("FAIL remu0_tag got=%h exp=8", tag_out); end
    pop();
    issue(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    wait_out(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
    total++; if (result !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_div got=%h exp=8000000000000000", result); end
    pop();
    issue(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
    wait_out(lat);
    total++; if (result !== 64'd0) begin bad++; $display("FAIL ovf_rem got=%h exp=0", result); end
    pop();
  endtask

  task automatic test_word;
    int lat;
    issue(2'd0, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF, 5'd11);
    wait_out(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL divw_ovf_latency got=%0d exp=1", lat); end
    total++; if (result !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL divw_ovf got=%h exp=ffffffff80000000", result); end
    pop();
    issue(2'd1, 1'b1, 64'hFFFF_FFFE, 64'd1, 5'd12);
    wait_out(lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL divuw_latency got=%0d exp=34", lat); end
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL divuw_result got=%h exp=fffffffffffffffe", result); end
    pop();
    issue(2'd2, 1'b1, 64'h5_FFFF_FFF9, 64'h7_0000_0002, 5'd13);
    wait_out(lat);
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL remw_result got=%h exp=ffffffffffffffff", result); end
    pop();
  endtask

  task automatic test_backpressure_kill;
    int lat;
    int unstable;
    unstable = 0;
    issue(2'd0, 1'b0, 64'd100, 64'd7, 5'd21);
    wait_out(lat);
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || result !== 64'd14 || tag_out !== 5'd21 || in_ready !== 1'b0) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL hold_stable bad_cycles=%0d exp=0 result=%h tag=%h", unstable, result, tag_out); end
    op = 2'd0; is_word = 1'b0; a = 64'd9; b = 64'd0; tag_in = 5'd22;
    in_valid = 1'b1; kill = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL kill_in_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kill_done_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_done_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL kill_done_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_kill_calc;
    int lat;
    int leaks;
    leaks = 0;
    issue(2'd1, 1'b0, 64'd999_999, 64'd3, 5'd25);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaks++;
    end
    total++; if (leaks !== 0) begin bad++; $display("FAIL kill_calc_leak cycles=%0d exp=0", leaks); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_calc_busy got=%b exp=0", busy); end
    issue(2'd3, 1'b0, 64'd1000, 64'd7, 5'd26);
    wait_out(lat);
    total++; if (lat !== 66) begin bad++; $display("FAIL post_kill_latency got=%0d exp=66", lat); end
    total++; if (result !== 64'd6) begin bad++; $display("FAIL post_kill_result got=%h exp=6", result); end
    total++; if (tag_out !== 5'd26) begin bad++; $display("FAIL post_kill_tag got=%h exp=1a", tag_out); end
    pop();
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(2'd0, 1'b0, 64'd12345, 64'd5, 5'd30);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    total++; if (result !== 64'd0) begin bad++; $display("FAIL rst_mid_result got=%h exp=0", result); end
    total++; if (tag_out !== 5'd0) begin bad++; $display("FAIL rst_mid_tag got=%h exp=0", tag_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 1'b0, 64'd7, -64'sd2, 5'd31);
    wait_out(lat);
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL post_rst_result got=%h exp=fffffffffffffffd", result); end
    total++; if (tag_out !== 5'd31) begin bad++; $display("FAIL post_rst_tag got=%h exp=1f", tag_out); end
    pop();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_word();
    test_backpressure_kill();
    test_kill_calc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
